// File: rtl/branch_resolve_unit.sv
// Commit-side branch resolution: registered mispredict/redirect plus an in-order
// training-update FIFO. Optional counters enabled by defining BR_RESOLVE_STATS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module branch_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int XLEN  = `XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rob_br_valid,
  output logic            rob_br_ready,
  input  logic [XLEN-1:0] rob_br_pc,
  input  logic            rob_br_taken,
  input  logic [XLEN-1:0] rob_br_target,
  input  logic            rob_br_pred_taken,
  input  logic [XLEN-1:0] rob_br_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [XLEN-1:0] upd_pc,
  output logic            upd_taken,
  output logic [XLEN-1:0] upd_target
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            full;
  logic            empty;
  logic            accept;
  logic            dequeue;
  logic            mis_now;
  logic [XLEN-1:0] next_pc;

  logic [XLEN-1:0] mem_pc     [DEPTH];
  logic            mem_taken  [DEPTH];
  logic [XLEN-1:0] mem_target [DEPTH];

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign rob_br_ready = !full;
  assign upd_valid    = !empty;
  assign accept       = rob_br_valid && rob_br_ready;
  assign dequeue      = upd_valid && upd_ready;

  assign mis_now = (rob_br_pred_taken != rob_br_taken) ||
                   (rob_br_taken && (rob_br_pred_target != rob_br_target));
  assign next_pc = rob_br_taken ? rob_br_target : rob_br_pc + XLEN'(4);

  assign upd_pc     = mem_pc[rd_ptr[AW-1:0]];
  assign upd_taken  = mem_taken[rd_ptr[AW-1:0]];
  assign upd_target = mem_target[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_pc[wr_ptr[AW-1:0]]     <= rob_br_pc;
      mem_taken[wr_ptr[AW-1:0]]  <= rob_br_taken;
      mem_target[wr_ptr[AW-1:0]] <= rob_br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      if (accept)  wr_ptr <= wr_ptr + 1'b1;
      if (dequeue) rd_ptr <= rd_ptr + 1'b1;
      mispredict <= accept && mis_now;
      if (accept && mis_now) redirect_pc <= next_pc;
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (accept && (stat_branches != '1))
        stat_branches <= stat_branches + 32'd1;
      if (accept && mis_now && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
